// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/settle/capture/writeback sequencer for the datapath ALU
module alu_op_sequencer #(
  parameter int         ALU_SETTLE = 2,
  parameter logic [4:0] OP_MUL     = 5'b01110,
  parameter logic [4:0] OP_DIV     = 5'b01111,
  parameter logic [4:0] OP_NOP     = 5'b11001,
  parameter logic [4:0] OP_HALT    = 5'b11010
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_hi,
  output logic        rsp_last,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, SETTLE, WB_LO, WB_HI} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        wide;
  logic [63:0] z;
  logic        accept;
  logic        settle_done;
  logic        no_beat;

  assign accept      = (state == IDLE) && req_valid && !halted;
  assign settle_done = (state == SETTLE) && (cnt == 4'd0);
  assign no_beat     = (alu_opcode == OP_NOP) || (alu_opcode == OP_HALT);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = no_beat ? IDLE : WB_LO;
      WB_LO:   if (rsp_ready) state_nxt = wide ? WB_HI : IDLE;
      WB_HI:   if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !halted;
    busy      = (state != IDLE);
    rsp_valid = 1'b0;
    rsp_data  = 32'd0;
    rsp_hi    = 1'b0;
    rsp_last  = 1'b0;
    case (state)
      WB_LO: begin
        rsp_valid = 1'b1;
        rsp_data  = z[31:0];
        rsp_last  = !wide;
      end
      WB_HI: begin
        rsp_valid = 1'b1;
        rsp_data  = z[63:32];
        rsp_hi    = 1'b1;
        rsp_last  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU operands stay registered across IDLE so the combinational ALU never sees request-bus churn
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      alu_y      <= 32'd0;
      alu_b      <= 32'd0;
      alu_opcode <= 5'b00000;
      wide       <= 1'b0;
      cnt        <= 4'd0;
      z          <= 64'd0;
      halted     <= 1'b0;
    end else begin
      if (accept) begin
        alu_y      <= req_a;
        alu_b      <= req_b;
        alu_opcode <= req_opcode;
        wide       <= (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
        cnt        <= 4'(ALU_SETTLE - 1);
      end else if ((state == SETTLE) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (settle_done) begin
        if (alu_opcode == OP_HALT) begin
          halted <= 1'b1;
        end else if (alu_opcode != OP_NOP) begin
          z <= alu_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer across several settle windows
module tb_alu_op_sequencer;

  localparam int          N          = 4;
  localparam logic [15:0] SETTLE_TAB = {4'd15, 4'd1, 4'd4, 4'd2};
  localparam logic [4:0]  OP_ADD     = 5'b00011;
  localparam logic [4:0]  OP_SUB     = 5'b00100;
  localparam logic [4:0]  OP_XOR     = 5'b00101;
  localparam logic [4:0]  OP_MUL     = 5'b01110;
  localparam logic [4:0]  OP_DIV     = 5'b01111;
  localparam logic [4:0]  OP_NOP     = 5'b11001;
  localparam logic [4:0]  OP_HALT    = 5'b11010;

  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] data;
    logic        hi;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]        clear, req_valid, req_ready, rsp_valid, rsp_ready, rsp_hi, rsp_last, busy, halted;
  logic [N-1:0][4:0]   req_opcode, alu_opcode;
  logic [N-1:0][31:0]  req_a, req_b, alu_y, alu_b, rsp_data;
  logic [N-1:0][63:0]  alu_c;

  beat_t              exp_q[$];
  logic [N-1:0]       stall_pend;
  logic [N-1:0][33:0] held;
  int                 errors;
  int                 checks;

  // Environment ALU: upper half of non-wide results is junk that must never be emitted
  function automatic logic [63:0] alu_fn(logic [4:0] op, logic [31:0] y, logic [31:0] b);
    case (op)
      OP_ADD:  return {32'hA5A5_A5A5, y + b};
      OP_SUB:  return {32'h5A5A_5A5A, y - b};
      OP_XOR:  return {~(y ^ b), y ^ b};
      OP_MUL:  return 64'(y) * 64'(b);
      OP_DIV:  return (b == 32'd0) ? {y, 32'hFFFF_FFFF} : {y % b, y / b};
      default: return 64'd0;
    endcase
  endfunction

  function automatic int settle_of(int g);
    return int'(SETTLE_TAB[g*4 +: 4]);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    alu_op_sequencer #(.ALU_SETTLE(int'(SETTLE_TAB[g*4 +: 4]))) u_dut (
      .clk        (clk),
      .clear      (clear[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_opcode (req_opcode[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .alu_y      (alu_y[g]),
      .alu_b      (alu_b[g]),
      .alu_opcode (alu_opcode[g]),
      .alu_c      (alu_c[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .rsp_hi     (rsp_hi[g]),
      .rsp_last   (rsp_last[g]),
      .busy       (busy[g]),
      .halted     (halted[g])
    );
    assign alu_c[g] = alu_fn(alu_opcode[g], alu_y[g], alu_b[g]);
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: NOP/HALT give no beats, MUL/DIV give LO then HI, everything else one LO beat
  task automatic push_expect(int g, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] r;
    r = alu_fn(op, a, b);
    if (op == OP_NOP || op == OP_HALT) return;
    if (op == OP_MUL || op == OP_DIV) begin
      exp_q.push_back('{g: 2'(g), data: r[31:0], hi: 1'b0, last: 1'b0});
      exp_q.push_back('{g: 2'(g), data: r[63:32], hi: 1'b1, last: 1'b1});
    end else begin
      exp_q.push_back('{g: 2'(g), data: r[31:0], hi: 1'b0, last: 1'b1});
    end
  endtask

  task automatic monitor();
    beat_t e;
    for (int g = 0; g < N; g++) begin
      if (stall_pend[g] && clear[g]) begin
        check("stall_hold_valid", 64'(rsp_valid[g]), 64'd1);
        check("stall_hold_beat", 64'({rsp_data[g], rsp_hi[g], rsp_last[g]}), 64'(held[g]));
      end
      stall_pend[g] = rsp_valid[g] && !rsp_ready[g] && clear[g];
      held[g]       = {rsp_data[g], rsp_hi[g], rsp_last[g]};
      if (rsp_valid[g] && rsp_ready[g]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'({rsp_data[g], rsp_hi[g], rsp_last[g]}), 64'h3_0000_0000 | 64'(g));
        end else begin
          e = exp_q.pop_front();
          check("beat_instance", 64'(g), 64'(e.g));
          check("beat", 64'({rsp_data[g], rsp_hi[g], rsp_last[g]}), 64'({e.data, e.hi, e.last}));
        end
      end
    end
  endtask

  task automatic check_reset(int g);
    check("rst_alu_y", 64'(alu_y[g]), 64'd0);
    check("rst_alu_b", 64'(alu_b[g]), 64'd0);
    check("rst_alu_opcode", 64'(alu_opcode[g]), 64'd0);
    check("rst_rsp", 64'({rsp_valid[g], rsp_data[g], rsp_hi[g], rsp_last[g]}), 64'd0);
    check("rst_busy_halted", 64'({busy[g], halted[g]}), 64'd0);
    check("rst_req_ready", 64'(req_ready[g]), 64'd1);
  endtask

  task automatic issue(int g, logic [4:0] op, logic [31:0] a, logic [31:0] b);
    int n = 0;
    while (!req_ready[g] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("issue_ready_timeout", 64'(req_ready[g]), 64'd1);
    req_valid[g]  = 1'b1;
    req_opcode[g] = op;
    req_a[g]      = a;
    req_b[g]      = b;
    push_expect(g, op, a, b);
    step();
    req_valid[g]  = 1'b0;
    req_opcode[g] = 5'($urandom);
    req_a[g]      = $urandom;
    req_b[g]      = $urandom;
  endtask

  // Counts falling edges after the accept edge until the watched signal rises
  task automatic measure(int g, bit want_valid, output int k);
    k = 0;
    for (int i = 1; i <= settle_of(g) + 6; i++) begin
      @(negedge clk);
      if (want_valid ? rsp_valid[g] : req_ready[g]) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_valid(int g);
    int n = 0;
    while (!rsp_valid[g] && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("wait_valid_timeout", 64'(rsp_valid[g]), 64'd1);
  endtask

  task automatic wait_idle(int g, bit rnd);
    int n = 0;
    while ((busy[g] || exp_q.size() != 0) && n < 300) begin
      if (rnd) rsp_ready[g] = ($urandom_range(0, 2) != 0);
      step();
      n++;
    end
    if (n >= 300) check("idle_timeout", 64'(busy[g]), 64'd0);
    rsp_ready[g] = 1'b1;
  endtask

  task automatic directed_add(int g, logic [31:0] a, logic [31:0] b);
    int k;
    rsp_ready[g] = 1'b1;
    issue(g, OP_ADD, a, b);
    measure(g, 1'b1, k);
    check("add_latency", 64'(k), 64'(settle_of(g) + 1));
    check("add_alu_y_held", 64'(alu_y[g]), 64'(a));
    check("add_alu_b_held", 64'(alu_b[g]), 64'(b));
    @(negedge clk);
    check("add_busy_drop", 64'(busy[g]), 64'd0);
    step();
  endtask

  task automatic run_tests();
    int          k;
    logic [4:0]  op;
    logic [31:0] a, b;

    #12;
    for (int g = 0; g < N; g++) check_reset(g);
    step();
    clear = '1;
    step();

    directed_add(0, 32'd5, 32'd7);

    rsp_ready[0] = 1'b1;
    issue(0, OP_MUL, 32'h0001_0000, 32'h0001_0000);
    wait_idle(0, 1'b0);

    rsp_ready[0] = 1'b0;
    issue(0, OP_DIV, 32'd17, 32'd5);
    wait_valid(0);
    repeat (3) begin
      check("div_req_ready_lo_stall", 64'(req_ready[0]), 64'd0);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready[0] = 1'b0;
    check("div_hi_beat_shown", 64'({rsp_valid[0], rsp_hi[0]}), 64'd3);
    repeat (3) begin
      check("div_req_ready_hi_stall", 64'(req_ready[0]), 64'd0);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    check("div_req_ready_after", 64'(req_ready[0]), 64'd1);

    issue(0, OP_NOP, 32'd3, 32'd4);
    measure(0, 1'b0, k);
    check("nop_ready_return", 64'(k), 64'(settle_of(0) + 1));
    step();

    issue(0, OP_HALT, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (settle_of(0) + 1) step();
    check("halt_flag", 64'({halted[0], req_ready[0], busy[0]}), 64'b100);
    req_valid[0]  = 1'b1;
    req_opcode[0] = OP_ADD;
    req_a[0]      = 32'd99;
    req_b[0]      = 32'd1;
    repeat (8) begin
      step();
      check("halt_blocks_req", 64'(req_ready[0]), 64'd0);
    end
    check("halt_alu_y_kept", 64'(alu_y[0]), 64'h1234_5678);
    check("halt_opcode_kept", 64'(alu_opcode[0]), 64'(OP_HALT));
    req_valid[0] = 1'b0;
    clear[0] = 1'b0;
    #2;
    check("halt_cleared", 64'(halted[0]), 64'd0);
    step();
    clear[0] = 1'b1;
    step();
    directed_add(0, 32'd1, 32'd1);

    rsp_ready[1] = 1'b1;
    issue(1, OP_MUL, 32'h0000_0300, 32'h0000_0020);
    step();
    check("mid_settle_busy", 64'(busy[1]), 64'd1);
    clear[1] = 1'b0;
    #1;
    check_reset(1);
    exp_q.delete();
    step();
    clear[1] = 1'b1;
    repeat (8) step();
    check("post_reset_idle", 64'(busy[1]), 64'd0);

    rsp_ready[1] = 1'b0;
    issue(1, OP_MUL, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_valid(1);
    rsp_ready[1] = 1'b1;
    step();
    rsp_ready[1] = 1'b0;
    check("mid_wbhi_shown", 64'({rsp_valid[1], rsp_hi[1]}), 64'd3);
    clear[1] = 1'b0;
    #1;
    check_reset(1);
    exp_q.delete();
    step();
    clear[1] = 1'b1;
    rsp_ready[1] = 1'b1;
    repeat (6) step();
    directed_add(1, 32'd40, 32'd2);

    directed_add(2, 32'hFFFF_FFFF, 32'd1);
    directed_add(3, 32'hFFFF_FFFF, 32'd1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 6))
        0:       op = OP_ADD;
        1:       op = OP_SUB;
        2:       op = OP_XOR;
        3:       op = OP_MUL;
        4:       op = OP_DIV;
        5:       op = OP_NOP;
        default: begin
          op = 5'($urandom);
          if (op == OP_HALT) op = 5'b11111;
        end
      endcase
      a = $urandom;
      b = (op == OP_DIV && $urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 20)) : $urandom;
      rsp_ready[0] = ($urandom_range(0, 1) == 1);
      issue(0, op, a, b);
      wait_idle(0, 1'b1);
    end
    repeat (3) step();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    stall_pend = '0;
    held       = '0;
    clear      = '0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = '1;
    fork
      forever begin
        @(negedge clk);
        monitor();
      end
      run_tests();
      begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: run did not complete within time budget");
      end
    join_any
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
